// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO: Gray/binary conversion and default sizing.
package fifo_pkg;

  localparam int ADDRSIZE_DEF    = 9;
  localparam int SYNC_STAGES_DEF = 2;

  // Conversions work on a 32-bit container; callers cast to their pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/wptr_full_lvl_if.sv
// Write-side FIFO bundle: requests and read pointer in, address, pointer and status out.
interface wptr_full_lvl_if #(
  parameter int ADDRSIZE = fifo_pkg::ADDRSIZE_DEF
) ();

  logic                winc;
  logic                wclr_ovf;
  logic [ADDRSIZE:0]   waf_thresh;
  logic [ADDRSIZE:0]   rptr;
  logic [ADDRSIZE-1:0] waddr;
  logic [ADDRSIZE:0]   wptr;
  logic                wfull;
  logic                walmost_full;
  logic [ADDRSIZE:0]   wlevel;
  logic                wovf;

  modport master (
    output winc, wclr_ovf, waf_thresh, rptr,
    input  waddr, wptr, wfull, walmost_full, wlevel, wovf
  );

  modport slave (
    input  winc, wclr_ovf, waf_thresh, rptr,
    output waddr, wptr, wfull, walmost_full, wlevel, wovf
  );

endinterface

// File: rtl/sync_nff.sv
// STAGES-deep, WIDTH-wide flop chain for bringing a Gray pointer into another clock domain.
module sync_nff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain;

  // NOTE: every stage is reset so a stale pointer never escapes after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/wptr_full_lvl.sv
// Write-domain pointer, fill level, full/almost-full and sticky overflow for the async FIFO.
module wptr_full_lvl
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE    = ADDRSIZE_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic           wclk,
  input  logic           wrst,
  wptr_full_lvl_if.slave bus
);

  localparam int PW = ADDRSIZE + 1;

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbinnext;
  logic [PW-1:0] wgraynext;
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] wq_rptr;
  logic [PW-1:0] rbin;
  logic [PW-1:0] level_next;
  logic [PW-1:0] wlevel_q;
  logic          wen;
  logic          full_next;
  logic          wfull_q;
  logic          waf_q;
  logic          wovf_q;

  // The raw Gray pointer goes straight into the first flop; no logic in front of it.
  sync_nff #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk (wclk),
    .rst (wrst),
    .d   (bus.rptr),
    .q   (wq_rptr)
  );

  assign wen        = bus.winc & ~wfull_q;
  assign wbinnext   = wbin + {{ADDRSIZE{1'b0}}, wen};
  assign wgraynext  = PW'(bin2gray(32'(wbinnext)));
  assign rbin       = PW'(gray2bin(32'(wq_rptr)));
  assign level_next = wbinnext - rbin;

  // Full when the next write pointer equals the read pointer with the top two Gray bits flipped.
  assign full_next = (wgraynext == {~wq_rptr[ADDRSIZE:ADDRSIZE-1], wq_rptr[ADDRSIZE-2:0]});

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin     <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      waf_q    <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin     <= wbinnext;
      wptr_q   <= wgraynext;
      wlevel_q <= level_next;
      wfull_q  <= full_next;
      waf_q    <= (level_next >= bus.waf_thresh);
      // A rejected write in the same cycle as a clear keeps the flag set.
      wovf_q   <= (bus.winc & wfull_q) | (wovf_q & ~bus.wclr_ovf);
    end
  end

  assign bus.waddr        = wbin[ADDRSIZE-1:0];
  assign bus.wptr         = wptr_q;
  assign bus.wlevel       = wlevel_q;
  assign bus.wfull        = wfull_q;
  assign bus.walmost_full = waf_q;
  assign bus.wovf         = wovf_q;

endmodule

// File: tb/tb_wptr_full_lvl.sv
// Directed and scoreboarded checks of wptr_full_lvl with ADDRSIZE=4, SYNC_STAGES=2.
module tb_wptr_full_lvl;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic wclk = 1'b0;
  logic wrst = 1'b1;

  int checks = 0;
  int errors = 0;

  wptr_full_lvl_if #(.ADDRSIZE(AW)) bus ();

  wptr_full_lvl #(
    .ADDRSIZE    (AW),
    .SYNC_STAGES (2)
  ) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus)
  );

  always #5 wclk = ~wclk;

  function automatic logic [4:0] to_gray(input logic [4:0] b);
    return b ^ {1'b0, b[4:1]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One wclk edge, then sample 1 ns later and check the full/level equivalence.
  task automatic step();
    @(posedge wclk);
    #1;
    check("full_eq_level", 32'(bus.wfull), 32'(bus.wlevel == 5'(DEPTH)));
  endtask

  logic [4:0] wcnt;
  logic [4:0] rcnt;
  logic [4:0] prev_wptr;
  logic [4:0] hist [3];
  logic [4:0] lvl_exp;
  logic       full_exp;
  logic       acc;
  logic [4:0] thr_tab [5];

  initial begin
    bus.winc       = 1'b0;
    bus.wclr_ovf   = 1'b0;
    bus.waf_thresh = 5'd12;
    bus.rptr       = 5'd0;

    // 1. Reset, 5 writes, asynchronous mid-stream reset, first write lands at 0
    step();
    check("rst_waddr", 32'(bus.waddr), 32'd0);
    check("rst_wovf", 32'(bus.wovf), 32'd0);
    wrst = 1'b0;
    bus.winc = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("pre_rst_waddr", 32'(bus.waddr), 32'd5);
    check("pre_rst_wlevel", 32'(bus.wlevel), 32'd5);
    bus.winc = 1'b0;
    #2 wrst = 1'b1;
    #1;
    check("async_rst_waddr", 32'(bus.waddr), 32'd0);
    check("async_rst_wptr", 32'(bus.wptr), 32'd0);
    check("async_rst_wlevel", 32'(bus.wlevel), 32'd0);
    check("async_rst_wfull", 32'(bus.wfull), 32'd0);
    check("async_rst_wovf", 32'(bus.wovf), 32'd0);
    #1 wrst = 1'b0;
    bus.winc = 1'b1;
    check("first_wr_addr", 32'(bus.waddr), 32'd0);
    step();
    check("after_first_waddr", 32'(bus.waddr), 32'd1);
    check("after_first_wptr", 32'(bus.wptr), 32'd1);
    check("after_first_wlevel", 32'(bus.wlevel), 32'd1);
    bus.winc = 1'b0;
    #1 wrst = 1'b1;
    #1 wrst = 1'b0;

    // 2. Fill 16 words with rptr=0, threshold 12
    bus.winc = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      check($sformatf("fill_wlevel_%0d", i), 32'(bus.wlevel), 32'(i));
      check($sformatf("fill_af_%0d", i), 32'(bus.walmost_full), 32'(i >= 12));
      check($sformatf("fill_wfull_%0d", i), 32'(bus.wfull), 32'(i == 16));
    end
    check("fill_waddr", 32'(bus.waddr), 32'd0);
    check("fill_wptr", 32'(bus.wptr), 32'b11000);
    check("fill_wovf", 32'(bus.wovf), 32'd0);

    // 3. Overflow while full, clear, and clear-vs-set
    for (int i = 0; i < 3; i++) begin
      step();
      check("ovf_wptr", 32'(bus.wptr), 32'b11000);
      check("ovf_wlevel", 32'(bus.wlevel), 32'd16);
      check("ovf_set", 32'(bus.wovf), 32'd1);
    end
    bus.winc     = 1'b0;
    bus.wclr_ovf = 1'b1;
    step();
    check("ovf_clear", 32'(bus.wovf), 32'd0);
    bus.winc = 1'b1;
    step();
    check("ovf_set_wins", 32'(bus.wovf), 32'd1);
    check("ovf_set_wins_wptr", 32'(bus.wptr), 32'b11000);
    bus.winc     = 1'b0;
    bus.wclr_ovf = 1'b0;

    // 4. Drain to read pointer 4: visible on the third edge
    bus.rptr = 5'b00110;
    for (int i = 1; i <= 2; i++) begin
      step();
      check($sformatf("drain_wfull_%0d", i), 32'(bus.wfull), 32'd1);
      check($sformatf("drain_wlevel_%0d", i), 32'(bus.wlevel), 32'd16);
    end
    step();
    check("drain_wfull_3", 32'(bus.wfull), 32'd0);
    check("drain_wlevel_3", 32'(bus.wlevel), 32'd12);
    check("drain_af_3", 32'(bus.walmost_full), 32'd1);

    // 5. Wrap: 40 writes with the read pointer trailing by 3 words
    wcnt = 5'd16;
    bus.rptr = to_gray(wcnt - 5'd3);
    for (int i = 0; i < 3; i++) step();
    check("wrap_start_level", 32'(bus.wlevel), 32'd3);
    bus.winc = 1'b1;
    for (int i = 0; i < 40; i++) begin
      prev_wptr = bus.wptr;
      step();
      wcnt = wcnt + 5'd1;
      check("wrap_wptr", 32'(bus.wptr), 32'(to_gray(wcnt)));
      check("wrap_waddr", 32'(bus.waddr), 32'(wcnt[3:0]));
      check("wrap_level_bound", 32'(bus.wlevel <= 5'd6), 32'd1);
      check("wrap_no_full", 32'(bus.wfull), 32'd0);
      if (wcnt == 5'd0) begin
        check("wrap_prev_wptr", 32'(prev_wptr), 32'b10000);
      end
      bus.rptr = to_gray(wcnt - 5'd3);
    end
    bus.winc = 1'b0;

    // 6. Random writes and reads against a delayed-read-pointer scoreboard
    #1 wrst = 1'b1;
    #1 wrst = 1'b0;
    bus.rptr = 5'd0;
    wcnt = '0;
    rcnt = '0;
    full_exp = 1'b0;
    for (int k = 0; k < 3; k++) hist[k] = '0;
    thr_tab[0] = 5'd12;
    thr_tab[1] = 5'd0;
    thr_tab[2] = 5'd16;
    thr_tab[3] = 5'd17;
    thr_tab[4] = 5'd31;
    for (int j = 0; j < 10000; j++) begin
      if (j % 2000 == 0) bus.waf_thresh = thr_tab[j / 2000];
      if (j < 5000) begin
        bus.winc = ($urandom_range(99) < 75);
        if (rcnt != wcnt && $urandom_range(99) < 40) rcnt = rcnt + 5'd1;
      end else begin
        bus.winc = ($urandom_range(99) < 45);
        if (rcnt != wcnt && $urandom_range(99) < 70) rcnt = rcnt + 5'd1;
      end
      bus.rptr = to_gray(rcnt);
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = rcnt;
      acc = bus.winc && !full_exp;
      if (acc) wcnt = wcnt + 5'd1;
      step();
      lvl_exp  = wcnt - hist[2];
      full_exp = (lvl_exp == 5'd16);
      check("rand_wlevel", 32'(bus.wlevel), 32'(lvl_exp));
      check("rand_wfull", 32'(bus.wfull), 32'(full_exp));
      check("rand_af", 32'(bus.walmost_full), 32'(lvl_exp >= bus.waf_thresh));
      check("rand_wptr", 32'(bus.wptr), 32'(to_gray(wcnt)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wptr_full_lvl.md
Name: wptr_full_lvl

Overview:
- Write-side pointer and status block for the dual-clock asynchronous FIFO, lives entirely in the write clock domain.
- Parametrised successor of the existing write-pointer/full logic. Adds:
  - an internal N-stage synchroniser for the read Gray pointer,
  - a registered fill-level count,
  - a runtime-programmable almost-full flag,
  - a sticky overflow flag.
- Feeds the FIFO memory write address and sends its Gray pointer to the read domain.

Parameters:
- ADDRSIZE, 9, FIFO address width; depth DEPTH = 2^ADDRSIZE; pointers are ADDRSIZE+1 bits.
- SYNC_STAGES, 2, number of flops synchronising rptr into wclk; legal range 2..4.

Ports:
- wclk  in  1  write-domain clock.
- wrst  in  1  write-domain reset, asynchronous, active-high.
- winc  in  1  write request for this cycle.
- wclr_ovf  in  1  clear sticky overflow flag.
- waf_thresh  in  ADDRSIZE+1  almost-full threshold in words; quasi-static.
- rptr  in  ADDRSIZE+1  read-domain Gray pointer; asynchronous to wclk.
- waddr  out  ADDRSIZE  memory write address (binary).
- wptr  out  ADDRSIZE+1  registered Gray write pointer to the read domain.
- wfull  out  1  FIFO full.
- walmost_full  out  1  level >= waf_thresh.
- wlevel  out  ADDRSIZE+1  words currently held, 0..DEPTH.
- wovf  out  1  sticky: a write was attempted while full.

Behaviour:
- Reset: one clock (wclk); reset is asynchronous and active-high (wrst). While wrst=1 the following are all 0 asynchronously:
  - every flop: wbin, wptr, synchroniser stages, wfull, walmost_full, wlevel, wovf;
  - waddr follows wbin, so it is also 0.
  - Reset mid-operation discards all state; the first accepted write after release goes to address 0.
- Write acceptance:
  - wen = winc & ~wfull.
  - wbinnext = wbin + wen, modulo 2^(ADDRSIZE+1).
  - wgraynext = (wbinnext >> 1) ^ wbinnext.
  - On each wclk edge, wbin <= wbinnext and wptr <= wgraynext.
  - waddr = wbin[ADDRSIZE-1:0], combinational from the register.
- Synchroniser:
  - rptr passes through SYNC_STAGES flops to give wq_rptr.
  - Only Gray values cross the domain; no logic is allowed before the first flop.
- Read-pointer conversion: rbin = Gray-to-binary(wq_rptr), combinational.
- Level:
  - wlevel <= (wbinnext - rbin) mod 2^(ADDRSIZE+1), registered.
  - Zero-latency relative to accepted writes: wlevel reflects a write at the same edge that consumes it.
- Full:
  - wfull <= (wgraynext == {~wq_rptr[ADDRSIZE:ADDRSIZE-1], wq_rptr[ADDRSIZE-2:0]}).
  - This must be equivalent to level_next == DEPTH; the bench asserts the two agree every cycle.
- Almost full:
  - walmost_full <= (level_next >= waf_thresh).
  - waf_thresh = 0 makes the flag constantly 1.
  - waf_thresh > DEPTH makes it constantly 0.
- Overflow:
  - set condition = winc & wfull.
  - wovf <= set | (wovf & ~wclr_ovf).
  - When set and clear occur in the same cycle, set wins.
  - A write while full never moves the pointers.
- Latency:
  - A read-side pointer change reaches wfull, wlevel and walmost_full after SYNC_STAGES+1 wclk edges.
  - The flags are pessimistic: they may show full or high level late, never early.
- Wrap-around:
  - wbin wraps from 2^(ADDRSIZE+1)-1 to 0; Gray wraps from 1 followed by zeros to all zeros.
  - The level arithmetic stays correct across the wrap.
- Simultaneous winc and read-pointer advance while full: the write is rejected in that cycle. The freed slot is seen only after synchronisation.

Decomposition:
- Shared package (fifo_pkg) holds:
  - the binary-to-Gray and Gray-to-binary functions,
  - the default ADDRSIZE and SYNC_STAGES constants.
- One natural sub-module: sync_nff, a parametrised SYNC_STAGES-deep, WIDTH-wide flop chain with async active-high reset. The read-domain counterpart reuses it.

Test Plan (ADDRSIZE=4, DEPTH=16, SYNC_STAGES=2):
1. Reset: assert wrst mid-stream after 5 writes -> waddr=0, wptr=0, wlevel=0, wfull=0, wovf=0 immediately without a clock edge; the next write lands at waddr=0.
2. Fill: rptr=0, waf_thresh=12, 16 consecutive winc ->
   - walmost_full=1 at the edge where wlevel=12;
   - after the 16th edge: wfull=1, wlevel=16, waddr=0, wptr=5'b11000.
3. Overflow: with full, winc=1 for 3 cycles ->
   - wptr stays 5'b11000, wlevel stays 16, wovf=1 from the first edge;
   - wclr_ovf pulse with winc=0 -> wovf=0;
   - wclr_ovf and a rejected winc in the same cycle -> wovf stays 1.
4. Drain: from full, set rptr=5'b00110 (binary 4) -> wfull and wlevel unchanged for 2 edges; on the 3rd edge wfull=0, wlevel=12, walmost_full=1.
5. Wrap: 40 writes with rptr following wptr delayed by 3 words -> wbin wraps 31->0 with wptr going 5'b10000->5'b00000; wlevel never exceeds 3+SYNC_STAGES+1 and wfull never asserts.
6. Random: random winc and read-model rptr for 10k cycles -> scoreboard level matches wlevel, the wfull equivalence holds, and no accepted write occurs while wfull=1.
